// File: rtl/mul_seq_xnyn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mul_seq_xnyn_pkg
// Description : Shared definitions for the sequential shift-add multiplier.
//               Holds the FSM state encoding (IDLE=0, RUN=1, FIX=2, DONE=3),
//               the ready-level constant and the default operand widths.
//               It also holds a small helper that decodes "can accept" from a
//               state value.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mul_seq_xnyn_pkg;

  // Default operand widths (match the 3x3 combinational predecessor)
  localparam int DEF_X_WIDTH = 3;
  localparam int DEF_Y_WIDTH = 3;

  // State encoding, kept as plain 2-bit constants for legacy compatibility
  localparam int          ST_WIDTH = 2;
  typedef logic [ST_WIDTH-1:0] state_t;

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_RUN   = 2'd1;
  localparam logic [1:0]  ST_FIX   = 2'd2;
  localparam logic [1:0]  ST_DONE  = 2'd3;

  // Level driven on rdy when the block can take a new request
  localparam logic        READY_TRUE = 1'b1;

  // A request can only be taken while idle or while holding a result
  function automatic logic is_ready_state(input state_t st);
    return ((st == ST_IDLE) || (st == ST_DONE)) ? READY_TRUE : ~READY_TRUE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_seq_xnyn_twos_neg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : twos_neg
// Description : Parametrised conditional two's-complement negator.
//               dout = en ? (~din + 1) : din
// Ports       : en   in  1      negate when high
//               din  in  WIDTH  value to pass or negate
//               dout out WIDTH  result (pure combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module twos_neg #(
  parameter int WIDTH = 3
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = en ? (~din + WIDTH'(1)) : din;

endmodule
`default_nettype wire

// File: rtl/mul_seq_xnyn.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mul_seq_xnyn
// Description : Sequential shift-add multiplier, one partial product per
//               clock, with an optional per-operation two's-complement mode.
//               Operands are converted to magnitudes on accept, so the core
//               loop is a plain unsigned shift-add. The sign is applied once
//               in the FIX state. Latency is Y_WIDTH+1 clocks from accept to
//               vld.
// Ports       : clk    in  1        rising-edge clock
//               rst_n  in  1        asynchronous active-low reset
//               start  in  1        request, taken on an edge while rdy=1
//               sgn    in  1        1 = operands are two's complement
//               x      in  X_WIDTH  multiplicand
//               y      in  Y_WIDTH  multiplier
//               rdy    out 1        block can accept start (IDLE or DONE)
//               vld    out 1        p/s hold a completed result
//               p      out P_WIDTH  product
//               s      out 1        result sign (0 in unsigned mode)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_xnyn
  import mul_seq_xnyn_pkg::*;
#(
  parameter int X_WIDTH = DEF_X_WIDTH,
  parameter int Y_WIDTH = DEF_Y_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sgn,
  input  logic [X_WIDTH-1:0]         x,
  input  logic [Y_WIDTH-1:0]         y,
  output logic                       rdy,
  output logic                       vld,
  output logic [X_WIDTH+Y_WIDTH-1:0] p,
  output logic                       s
);

  localparam int P_WIDTH   = X_WIDTH + Y_WIDTH;
  localparam int CNT_WIDTH = $clog2(Y_WIDTH + 1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t               state;
  logic [P_WIDTH:0]     acc;      // one extra bit catches the add carry
  logic [CNT_WIDTH-1:0] count;
  logic [X_WIDTH-1:0]   xm;       // multiplicand magnitude
  logic [Y_WIDTH-1:0]   ym;       // multiplier magnitude, shifted right per step
  logic                 sgn_q;
  logic                 s_q;
  logic                 vld_q;
  logic [P_WIDTH-1:0]   p_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [X_WIDTH-1:0]   x_mag;
  logic [Y_WIDTH-1:0]   y_mag;
  logic [P_WIDTH-1:0]   p_fix;
  logic [X_WIDTH-1:0]   addend;
  logic [X_WIDTH:0]     upper_sum;
  logic [P_WIDTH:0]     acc_next;
  logic                 accept;
  logic                 last_iter;

  // The most negative operand negates to itself, which read as unsigned is
  // exactly its magnitude, so X_WIDTH/Y_WIDTH bits are always enough.
  twos_neg #(.WIDTH(X_WIDTH)) u_neg_x (
    .en   (sgn & x[X_WIDTH-1]),
    .din  (x),
    .dout (x_mag)
  );

  twos_neg #(.WIDTH(Y_WIDTH)) u_neg_y (
    .en   (sgn & y[Y_WIDTH-1]),
    .din  (y),
    .dout (y_mag)
  );

  // Restore the sign of the magnitude product in the FIX state
  twos_neg #(.WIDTH(P_WIDTH)) u_neg_p (
    .en   (sgn_q & s_q),
    .din  (acc[P_WIDTH-1:0]),
    .dout (p_fix)
  );

  assign accept    = start & (is_ready_state(state) == READY_TRUE);
  assign last_iter = (count == CNT_WIDTH'(Y_WIDTH - 1));

  // Add into the upper X_WIDTH+1 bits (the top one holds the carry), then
  // shift the whole accumulator right so the carry lands in the product MSB.
  assign addend    = ym[0] ? xm : '0;
  assign upper_sum = acc[P_WIDTH:Y_WIDTH] + {1'b0, addend};
  assign acc_next  = {1'b0, upper_sum, acc[Y_WIDTH-1:1]};

  // --------------------------------------------------------------------------
  // FSM and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      count <= '0;
      xm    <= '0;
      ym    <= '0;
      sgn_q <= 1'b0;
      s_q   <= 1'b0;
      vld_q <= 1'b0;
      p_q   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            sgn_q <= sgn;
            s_q   <= sgn & (x[X_WIDTH-1] ^ y[Y_WIDTH-1]);
            xm    <= x_mag;
            ym    <= y_mag;
            acc   <= '0;
            count <= '0;
            vld_q <= 1'b0;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          acc   <= acc_next;
          ym    <= ym >> 1;
          count <= count + CNT_WIDTH'(1);
          if (last_iter) begin
            state <= ST_FIX;
          end
        end

        ST_FIX: begin
          p_q   <= p_fix;
          vld_q <= 1'b1;
          state <= ST_DONE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // All outputs come straight from registers (rdy is a decode of state only)
  assign rdy = is_ready_state(state);
  assign vld = vld_q;
  assign p   = p_q;
  assign s   = s_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_xnyn.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_xnyn
// Description : Self-checking bench for mul_seq_xnyn. Two instances: the
//               default 3x3 (A) and an 8x4 (B). Expected products come from
//               plain integer multiplication of the operand values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_xnyn;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_a = 1'b0, sgn_a = 1'b0;
  logic [2:0]  x_a = '0, y_a = '0;
  logic        rdy_a, vld_a, s_a;
  logic [5:0]  p_a;

  logic        start_b = 1'b0, sgn_b = 1'b0;
  logic [7:0]  x_b = '0;
  logic [3:0]  y_b = '0;
  logic        rdy_b, vld_b, s_b;
  logic [11:0] p_b;

  int tests = 0;
  int fails = 0;

  mul_seq_xnyn #(.X_WIDTH(3), .Y_WIDTH(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .sgn(sgn_a), .x(x_a), .y(y_a),
    .rdy(rdy_a), .vld(vld_a), .p(p_a), .s(s_a)
  );

  mul_seq_xnyn #(.X_WIDTH(8), .Y_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .sgn(sgn_b), .x(x_b), .y(y_b),
    .rdy(rdy_b), .vld(vld_b), .p(p_b), .s(s_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          sl;
    bit          sg;
    logic [7:0]  x;
    logic [3:0]  y;
    logic [11:0] p;
    bit          s;
  } vec_t;

  typedef struct {
    bit         sg;
    logic [2:0] x;
    logic [2:0] y;
  } op_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic m_rdy(input bit sl);
    return sl ? rdy_b : rdy_a;
  endfunction
  function automatic logic m_vld(input bit sl);
    return sl ? vld_b : vld_a;
  endfunction
  function automatic logic m_s(input bit sl);
    return sl ? s_b : s_a;
  endfunction
  function automatic logic [11:0] m_p(input bit sl);
    return sl ? p_b : {6'd0, p_a};
  endfunction

  // Reference: interpret operands as integers, multiply, wrap to P bits
  function automatic logic [11:0] model_p(input bit sl, input bit sg,
                                          input logic [7:0] xv, input logic [3:0] yv);
    int xw, yw, xi, yi, pr;
    xw = sl ? 8 : 3;
    yw = sl ? 4 : 3;
    xi = int'(xv) & ((1 << xw) - 1);
    yi = int'(yv) & ((1 << yw) - 1);
    if (sg && xi >= (1 << (xw - 1))) xi -= (1 << xw);
    if (sg && yi >= (1 << (yw - 1))) yi -= (1 << yw);
    pr = xi * yi;
    return 12'(pr & ((1 << (xw + yw)) - 1));
  endfunction

  function automatic bit model_s(input bit sl, input bit sg,
                                 input logic [7:0] xv, input logic [3:0] yv);
    int xw, yw, xi, yi;
    xw = sl ? 8 : 3;
    yw = sl ? 4 : 3;
    xi = int'(xv) & ((1 << xw) - 1);
    yi = int'(yv) & ((1 << yw) - 1);
    return sg && ((xi >= (1 << (xw - 1))) != (yi >= (1 << (yw - 1))));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sl, input bit st, input bit sg,
                       input logic [7:0] xv, input logic [3:0] yv);
    if (sl) begin
      start_b = st; sgn_b = sg; x_b = xv; y_b = yv;
    end else begin
      start_a = st; sgn_a = sg; x_a = xv[2:0]; y_a = yv[2:0];
    end
  endtask

  task automatic wait_rdy(input bit sl);
    int g;
    g = 0;
    while (m_rdy(sl) !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) check("rdy_wait_timeout", 32'd0, 32'd1);
  endtask

  // One complete operation; lat counts edges from accept to vld
  task automatic run_op(input bit sl, input bit sg, input logic [7:0] xv,
                        input logic [3:0] yv, output logic [11:0] pv,
                        output logic sv, output int lat, output logic busy);
    wait_rdy(sl);
    drive(sl, 1'b1, sg, xv, yv);
    tick();
    busy = m_rdy(sl);
    // operands may change freely once accepted
    drive(sl, 1'b0, ~sg, 8'($urandom), 4'($urandom));
    lat = 1;
    while (m_vld(sl) !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    lat--;
    pv = m_p(sl);
    sv = m_s(sl);
  endtask

  vec_t        tbl [12];
  op_t         pend [$];
  logic [11:0] pv;
  logic        sv, busy;
  int          lat;

  initial begin
    tbl[0]  = '{0, 0, 8'd7,   4'd7, 12'd49,   1'b0};
    tbl[1]  = '{0, 1, 8'd4,   4'd4, 12'd16,   1'b0};
    tbl[2]  = '{0, 1, 8'd5,   4'd2, 12'd58,   1'b1};
    tbl[3]  = '{0, 0, 8'd5,   4'd3, 12'd15,   1'b0};
    tbl[4]  = '{0, 1, 8'd7,   4'd7, 12'd1,    1'b0};
    tbl[5]  = '{0, 1, 8'd3,   4'd4, 12'd52,   1'b1};
    tbl[6]  = '{0, 0, 8'd0,   4'd5, 12'd0,    1'b0};
    tbl[7]  = '{0, 1, 8'd4,   4'd0, 12'd0,    1'b1};
    tbl[8]  = '{0, 0, 8'd4,   4'd4, 12'd16,   1'b0};
    tbl[9]  = '{1, 0, 8'd255, 4'd15, 12'd3825, 1'b0};
    tbl[10] = '{1, 1, 8'h80,  4'h8, 12'd1024, 1'b0};
    tbl[11] = '{1, 1, 8'hFF,  4'h7, 12'd4089, 1'b1};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_rdy_%0d", k), 32'(m_rdy(k[0])), 32'd1);
      check($sformatf("reset_vld_%0d", k), 32'(m_vld(k[0])), 32'd0);
      check($sformatf("reset_p_%0d", k),   32'(m_p(k[0])),   32'd0);
      check($sformatf("reset_s_%0d", k),   32'(m_s(k[0])),   32'd0);
    end
    rst_n = 1'b1;
    tick();

    // ---------------- directed table ----------------
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].sl, tbl[i].sg, tbl[i].x, tbl[i].y, pv, sv, lat, busy);
      check($sformatf("tbl%0d_p", i),    32'(pv), 32'(tbl[i].p));
      check($sformatf("tbl%0d_s", i),    32'(sv), 32'(tbl[i].s));
      check($sformatf("tbl%0d_lat", i),  32'(lat), tbl[i].sl ? 32'd5 : 32'd4);
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("tbl%0d_rdy", i),  32'(m_rdy(tbl[i].sl)), 32'd1);
    end

    // ---------------- exhaustive 3x3, start held high ----------------
    begin
      int idx, cyc, last_rise;
      bit prev_vld, acc_prev;
      op_t o;
      idx = 0; cyc = 0; last_rise = -1;
      prev_vld = vld_a;
      acc_prev = 1'b0;
      while ((idx < 128 || pend.size() > 0) && cyc < 2000) begin
        if (acc_prev) check("b2b_vld_drop", 32'(vld_a), 32'd0);
        if (vld_a && !prev_vld) begin
          if (pend.size() > 0) begin
            o = pend.pop_front();
            check($sformatf("b2b_p_sg%0d_x%0d_y%0d", o.sg, o.x, o.y), 32'(p_a),
                  32'(model_p(1'b0, o.sg, {5'd0, o.x}, {1'b0, o.y})));
            check($sformatf("b2b_s_sg%0d_x%0d_y%0d", o.sg, o.x, o.y), 32'(s_a),
                  32'(model_s(1'b0, o.sg, {5'd0, o.x}, {1'b0, o.y})));
          end else begin
            check("b2b_unexpected_vld", 32'd1, 32'd0);
          end
          if (last_rise >= 0) check("b2b_gap", 32'(cyc - last_rise), 32'd5);
          last_rise = cyc;
        end
        prev_vld = vld_a;
        acc_prev = 1'b0;
        if (rdy_a && idx < 128) begin
          o.sg = idx[6]; o.x = idx[5:3]; o.y = idx[2:0];
          drive(1'b0, 1'b1, o.sg, {5'd0, o.x}, {1'b0, o.y});
          pend.push_back(o);
          idx++;
          acc_prev = 1'b1;
        end else if (idx >= 128) begin
          start_a = 1'b0;
        end
        tick();
        cyc++;
      end
      if (cyc >= 2000) check("b2b_timeout", 32'd0, 32'd1);
      start_a = 1'b0;
    end

    // ---------------- start while busy is ignored ----------------
    wait_rdy(1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd5, 4'd3);
    tick();                                   // accept
    drive(1'b0, 1'b1, 1'b0, 8'd7, 4'd7);
    tick();                                   // cycle 1 pulse
    drive(1'b0, 1'b1, 1'b1, 8'd6, 4'd6);
    tick();                                   // cycle 2 pulse
    drive(1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    lat = 2;
    while (vld_a !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    check("ign_lat", 32'(lat), 32'd4);
    check("ign_p", 32'(p_a), 32'd15);
    tick();
    check("ign_no_queue_vld", 32'(vld_a), 32'd1);
    check("ign_no_queue_rdy", 32'(rdy_a), 32'd1);

    // ---------------- reset in the middle of RUN ----------------
    drive(1'b0, 1'b1, 1'b1, 8'd5, 4'd2);
    tick();                                   // accept, s latched
    drive(1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    check("mid_s_latched", 32'(s_a), 32'd1);
    tick();
    tick();                                   // two iterations done
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(rdy_a), 32'd1);
    check("mid_rst_vld", 32'(vld_a), 32'd0);
    check("mid_rst_p",   32'(p_a),   32'd0);
    check("mid_rst_s",   32'(s_a),   32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_vld", 32'(vld_a), 32'd0);
    run_op(1'b0, 1'b0, 8'd5, 4'd3, pv, sv, lat, busy);
    check("post_rst_p",   32'(pv),  32'd15);
    check("post_rst_lat", 32'(lat), 32'd4);

    // ---------------- random sweep on the 8x4 instance ----------------
    for (int i = 0; i < 40; i++) begin
      bit          sg;
      logic [7:0]  xr;
      logic [3:0]  yr;
      sg = 1'($urandom_range(0, 1));
      xr = 8'($urandom);
      yr = 4'($urandom);
      run_op(1'b1, sg, xr, yr, pv, sv, lat, busy);
      check($sformatf("rnd%0d_p_sg%0d_x%0h_y%0h", i, sg, xr, yr), 32'(pv),
            32'(model_p(1'b1, sg, xr, yr)));
      check($sformatf("rnd%0d_s", i), 32'(sv), 32'(model_s(1'b1, sg, xr, yr)));
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
